phy_mem_io: RTL and testbench
=============================

Name: phy_mem_io

Overview:
- Next-generation physical memory block for the CPU's `if_memory` bus.
- Contains one dual-port on-chip RAM:
  - instruction port: read only;
  - data port: read/write with byte enables.
- Decodes a memory-mapped IO region that holds real registers:
  - N_GPIO output registers (GPIO 0 drives the board LEDs);
  - a writable free-running timer;
  - a timer compare register with a sticky interrupt;
  - a read-only ID word.
- Generates instruction and data bus errors for accesses outside RAM and IO.

Parameters:
- RAM_DEPTH, 14, RAM holds 2^RAM_DEPTH 32-bit words. The IO region is selected by dADDR[RAM_DEPTH]=1.
- N_GPIO, 2, number of 32-bit GPIO output registers. Range 1..8.
- LED_W, 8, width of LEDS. Must be ≤32. LEDS is taken from GPIO0[LED_W-1:0].
- ID_VALUE, 32'hFEEDDEAD, constant returned by the ID register.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- LEDS  output  LED_W  GPIO0[LED_W-1:0].
- IRQ  output  1  timer-match interrupt pending (level).
- MEM  if_memory.mem  -  word-addressed bus. Members used:
  - iADDR[29:0] in, iDATA[31:0] out, IBE out;
  - dADDR[29:0] in, RE in, WE in, BE[3:0] in, WD[31:0] in, dDATA[31:0] out, DBE out.

Behaviour:
- Decode:
  - io_req = dADDR[RAM_DEPTH];
  - oob = (dADDR[29:RAM_DEPTH+1] != 0);
  - IO word index = dADDR[3:0]; IO address bits above bit 3 are ignored, so the 16 words alias through the region.
- Bus errors (combinational, same cycle):
  - IBE = (iADDR[29:RAM_DEPTH+1] != 0);
  - DBE = (RE|WE) & oob.
- RAM write strobe = WE & ~io_req & ~oob, with byte enables BE.
- RAM read latency is 1 cycle on both ports:
  - iDATA = RAM[iADDR[RAM_DEPTH-1:0]] captured at the previous edge;
  - RAM contents are not reset.
- IO reads are also 1-cycle latency:
  - io_rdata is registered at the edge where the address is presented;
  - io_req is registered as io_req_q;
  - dDATA = io_req_q ? io_rdata_q : ram_rdata.
- IO register map (word index):
  - 0..N_GPIO-1 GPIO[n]: RW. Byte-granular writes per BE.
  - 8 TIMER: RW.
    - Increments by 1 every cycle and wraps 32'hFFFFFFFF→0.
    - A write loads WD with BE applied to the pre-increment value. A write wins over the increment that cycle; incrementing resumes on the next cycle.
  - 9 CMP: RW with BE.
  - 10 STATUS: bit0 = pending; other bits read 0.
    - A write with BE[0]=1 and WD[0]=1 clears pending (write-1-to-clear).
  - 11 ID: RO, returns ID_VALUE. Writes are ignored.
  - All other indices, including unused GPIO slots: read 0, writes ignored.
- IO writes take effect at the clock edge where WE & io_req & ~oob is high.
  - A read of the same register in the cycle after the write returns the new value. Exception: TIMER, which shows the loaded value and then continues counting.
- Interrupt:
  - pending sets at the edge after TIMER == CMP, comparing register values, not the incremented value.
  - Set wins over a simultaneous W1C clear.
  - pending stays high until cleared. IRQ = pending.
- RE is not required for IO reads. IO reads have no side effects, including STATUS.
- RESET (synchronous), at the next edge:
  - all GPIO, TIMER, CMP, pending, io_rdata_q and io_req_q go to 0;
  - LEDS=0, IRQ=0, dDATA selects RAM.
  - RESET mid-transaction discards the write in that cycle. The RAM write in that cycle is still performed: RAM has no reset.
- Since CMP resets to 0 and TIMER starts at 0, pending sets 1 cycle after reset deasserts unless CMP is written first. Software must clear it.

Test Plan:
- RAM path: write 32'h12345678 to word 5 with BE=4'b0011, then read word 5 → dDATA=32'hxxxx5678 (low halfword updated) one cycle after the address; DBE=0, IBE=0.
- GPIO/LEDS: write GPIO0=32'h000000A5 at the IO base → LEDS=8'hA5 the next cycle; read back 32'h000000A5. Write index 7 → read 0. Read ID → 32'hFEEDDEAD.
- Timer/IRQ: write CMP=20, write TIMER=10 → IRQ rises at the edge after TIMER reads 20. W1C to STATUS drops IRQ. A W1C issued on the match cycle leaves IRQ=1.
- Timer wrap and write priority: load TIMER=32'hFFFFFFFE → reads FFFFFFFF then 0. Write TIMER in the same cycle as the increment → loaded value wins.
- Bus errors: dADDR bit RAM_DEPTH+1 set with RE=1 → DBE=1 and no RAM or IO write. Set WE=1 with RE=0 → DBE=1. iADDR high bits set → IBE=1.
- Reset: assert RESET mid-run with LEDS=8'hFF and IRQ=1 → both are 0 after one edge; TIMER reads 0, then 1, ...; RAM contents are preserved.

Source files
------------

// File: rtl/phy_mem_io.sv
// Physical memory block: dual-port RAM (instruction read, data read/write with byte enables)
// plus a memory-mapped IO region with GPIO, a writable timer, a compare/IRQ unit and an ID word.
module phy_mem_io #(
  parameter int          RAM_DEPTH = 14,
  parameter int          N_GPIO    = 2,
  parameter int          LED_W     = 8,
  parameter logic [31:0] ID_VALUE  = 32'hFEEDDEAD
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [LED_W-1:0] LEDS,
  output logic             IRQ,
  input  logic [29:0]      iADDR,
  output logic [31:0]      iDATA,
  output logic             IBE,
  input  logic [29:0]      dADDR,
  input  logic             RE,
  input  logic             WE,
  input  logic [3:0]       BE,
  input  logic [31:0]      WD,
  output logic [31:0]      dDATA,
  output logic             DBE
);

  localparam int WORDS = 1 << RAM_DEPTH;

  localparam logic [3:0] IDX_TIMER  = 4'd8;
  localparam logic [3:0] IDX_CMP    = 4'd9;
  localparam logic [3:0] IDX_STATUS = 4'd10;
  localparam logic [3:0] IDX_ID     = 4'd11;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Address decode and bus errors
  logic       io_req;
  logic       oob;
  logic       ram_we;
  logic       io_we;
  logic [3:0] io_idx;

  assign io_req = dADDR[RAM_DEPTH];
  assign oob    = (dADDR[29:RAM_DEPTH+1] != '0);
  assign io_idx = dADDR[3:0];
  assign ram_we = WE & ~io_req & ~oob;
  assign io_we  = WE & io_req & ~oob;
  assign IBE    = (iADDR[29:RAM_DEPTH+1] != '0);
  assign DBE    = (RE | WE) & oob;

  // RAM: read-first on the data port, contents never reset
  logic [31:0] ram_mem [WORDS];
  logic [31:0] ram_idata_q;
  logic [31:0] ram_ddata_q;

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (BE[b]) ram_mem[dADDR[RAM_DEPTH-1:0]][b*8 +: 8] <= WD[b*8 +: 8];
      end
    end
    ram_idata_q <= ram_mem[iADDR[RAM_DEPTH-1:0]];
    ram_ddata_q <= ram_mem[dADDR[RAM_DEPTH-1:0]];
  end

  assign iDATA = ram_idata_q;

  // IO registers
  logic [31:0] gpio_q [N_GPIO];
  logic [31:0] gpio_d [N_GPIO];
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pending_q, pending_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic        io_req_q;

  generate
    for (genvar gi = 0; gi < N_GPIO; gi++) begin : g_gpio
      assign gpio_d[gi] = (io_we && io_idx == 4'(gi)) ? apply_be(gpio_q[gi], WD, BE) : gpio_q[gi];
    end
  endgenerate

  always_comb begin
    timer_d = timer_q + 32'd1;
    cmp_d   = cmp_q;
    if (io_we && io_idx == IDX_TIMER) timer_d = apply_be(timer_q, WD, BE);
    if (io_we && io_idx == IDX_CMP)   cmp_d   = apply_be(cmp_q, WD, BE);
    // A match on the current register values outranks a same-cycle clear
    pending_d = pending_q;
    if (io_we && io_idx == IDX_STATUS && BE[0] && WD[0]) pending_d = 1'b0;
    if (timer_q == cmp_q) pending_d = 1'b1;
  end

  always_comb begin
    io_rdata_d = '0;
    for (int n = 0; n < N_GPIO; n++) begin
      if (io_idx == 4'(n)) io_rdata_d = gpio_q[n];
    end
    case (io_idx)
      IDX_TIMER:  io_rdata_d = timer_q;
      IDX_CMP:    io_rdata_d = cmp_q;
      IDX_STATUS: io_rdata_d = {31'd0, pending_q};
      IDX_ID:     io_rdata_d = ID_VALUE;
      default:    ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int n = 0; n < N_GPIO; n++) gpio_q[n] <= '0;
      timer_q    <= '0;
      cmp_q      <= '0;
      pending_q  <= 1'b0;
      io_rdata_q <= '0;
      io_req_q   <= 1'b0;
    end else begin
      for (int n = 0; n < N_GPIO; n++) gpio_q[n] <= gpio_d[n];
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      pending_q  <= pending_d;
      io_rdata_q <= io_rdata_d;
      io_req_q   <= io_req;
    end
  end

  assign dDATA = io_req_q ? io_rdata_q : ram_ddata_q;
  assign LEDS  = gpio_q[0][LED_W-1:0];
  assign IRQ   = pending_q;

endmodule

// File: tb/tb_phy_mem_io.sv
// Directed bench for phy_mem_io: read expectations go through a scoreboard queue that a
// monitor drains one cycle after each read; level outputs are checked inline.
module tb_phy_mem_io;

  localparam logic [29:0] IO  = 30'h0000_4000;
  localparam logic [29:0] OOB = 30'h0000_8000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  LEDS;
  logic        IRQ;
  logic [29:0] iADDR;
  logic [31:0] iDATA;
  logic        IBE;
  logic [29:0] dADDR;
  logic        RE, WE;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic [31:0] dDATA;
  logic        DBE;

  phy_mem_io dut (
    .CLK(CLK), .RESET(RESET), .LEDS(LEDS), .IRQ(IRQ),
    .iADDR(iADDR), .iDATA(iDATA), .IBE(IBE),
    .dADDR(dADDR), .RE(RE), .WE(WE), .BE(BE), .WD(WD),
    .dDATA(dDATA), .DBE(DBE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic sb_arm = 1'b0;
  logic arm_q  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: a read sampled at an edge presents its data until the next edge
  always @(posedge CLK) arm_q <= sb_arm;

  always @(negedge CLK) begin
    if (arm_q) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got dDATA %h with no expected entry", dDATA);
      end else begin
        mon_e = sb_q.pop_front();
        chk(mon_e.name, dDATA & mon_e.mask, mon_e.exp & mon_e.mask);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] be);
    dADDR = addr; WD = data; BE = be; WE = 1'b1; RE = 1'b0; sb_arm = 1'b0;
    step();
    WE = 1'b0;
  endtask

  task automatic rd(input string name, input logic [29:0] addr, input logic [31:0] exp,
                    input logic [31:0] mask);
    exp_t e;
    e.name = name; e.exp = exp; e.mask = mask;
    sb_q.push_back(e);
    dADDR = addr; RE = 1'b1; WE = 1'b0; sb_arm = 1'b1;
    step();
    RE = 1'b0; sb_arm = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; iADDR = '0; dADDR = '0; RE = 1'b0; WE = 1'b0; BE = '0; WD = '0;
    step(); step();
    chk("reset_leds", 32'(LEDS), 32'h0);
    chk("reset_irq", 32'(IRQ), 32'h0);
    RESET = 1'b0;
    step();
    chk("irq_after_reset_release", 32'(IRQ), 32'h1);

    // RAM path
    wr(30'd5, 32'h1234_5678, 4'b0011);
    rd("ram_word5_low_half", 30'd5, 32'h0000_5678, 32'h0000_FFFF);
    iADDR = 30'd5;
    step();
    chk("iport_word5", iDATA & 32'h0000_FFFF, 32'h0000_5678);
    chk("ibe_in_range", 32'(IBE), 32'h0);

    // GPIO, LEDS, ID, unused slots, aliasing
    wr(IO | 30'd0, 32'h0000_00A5, 4'hF);
    chk("leds_a5", 32'(LEDS), 32'h0000_00A5);
    rd("gpio0", IO | 30'd0, 32'h0000_00A5, 32'hFFFF_FFFF);
    wr(IO | 30'd1, 32'h1122_3344, 4'b0101);
    rd("gpio1_be", IO | 30'd1, 32'h0022_0044, 32'hFFFF_FFFF);
    wr(IO | 30'd7, 32'hDEAD_BEEF, 4'hF);
    rd("unused_idx7", IO | 30'd7, 32'h0, 32'hFFFF_FFFF);
    rd("id", IO | 30'd11, 32'hFEED_DEAD, 32'hFFFF_FFFF);
    wr(IO | 30'd11, 32'h0, 4'hF);
    rd("id_after_write", IO | 30'd11, 32'hFEED_DEAD, 32'hFFFF_FFFF);
    rd("gpio0_alias", IO | 30'h10, 32'h0000_00A5, 32'hFFFF_FFFF);
    rd("unused_idx12", IO | 30'd12, 32'h0, 32'hFFFF_FFFF);

    // Timer / compare / interrupt
    wr(IO | 30'd8, 32'd1000, 4'hF);
    wr(IO | 30'd9, 32'd20, 4'hF);
    wr(IO | 30'd10, 32'h1, 4'b0001);
    chk("irq_cleared", 32'(IRQ), 32'h0);
    rd("cmp", IO | 30'd9, 32'd20, 32'hFFFF_FFFF);
    rd("status_clear", IO | 30'd10, 32'h0, 32'hFFFF_FFFF);
    wr(IO | 30'd8, 32'd10, 4'hF);
    for (int k = 0; k < 10; k++) rd($sformatf("timer_%0d", 10 + k), IO | 30'd8, 32'(10 + k), 32'hFFFF_FFFF);
    chk("irq_before_match", 32'(IRQ), 32'h0);
    rd("timer_20", IO | 30'd8, 32'd20, 32'hFFFF_FFFF);
    chk("irq_on_match", 32'(IRQ), 32'h1);
    rd("status_pending", IO | 30'd10, 32'h1, 32'hFFFF_FFFF);
    wr(IO | 30'd10, 32'h1, 4'b0001);
    chk("irq_w1c", 32'(IRQ), 32'h0);
    wr(IO | 30'd8, 32'd15, 4'hF);
    repeat (5) step();
    wr(IO | 30'd10, 32'h1, 4'b0001);
    chk("irq_set_beats_clear", 32'(IRQ), 32'h1);
    wr(IO | 30'd10, 32'h1, 4'b0001);
    chk("irq_w1c_again", 32'(IRQ), 32'h0);

    // Timer wrap and write priority
    wr(IO | 30'd8, 32'hFFFF_FFFE, 4'hF);
    rd("timer_fffffffe", IO | 30'd8, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    rd("timer_ffffffff", IO | 30'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("timer_wrap_0", IO | 30'd8, 32'h0, 32'hFFFF_FFFF);
    wr(IO | 30'd8, 32'h1122_3344, 4'hF);
    wr(IO | 30'd8, 32'h0000_00AA, 4'b0001);
    rd("timer_be_load", IO | 30'd8, 32'h1122_33AA, 32'hFFFF_FFFF);

    // Bus errors
    dADDR = 30'd5; RE = 1'b1; #1;
    chk("dbe_in_range", 32'(DBE), 32'h0);
    dADDR = OOB | 30'd5; #1;
    chk("dbe_oob_read", 32'(DBE), 32'h1);
    RE = 1'b0; WE = 1'b1; WD = 32'hDEAD_BEEF; BE = 4'hF; #1;
    chk("dbe_oob_write", 32'(DBE), 32'h1);
    step();
    dADDR = OOB | IO | 30'd0;
    step();
    WE = 1'b0; #1;
    chk("dbe_idle", 32'(DBE), 32'h0);
    chk("leds_after_oob_write", 32'(LEDS), 32'h0000_00A5);
    rd("ram_after_oob_write", 30'd5, 32'h0000_5678, 32'h0000_FFFF);
    iADDR = OOB | 30'd5; #1;
    chk("ibe_oob", 32'(IBE), 32'h1);
    iADDR = 30'd5;

    // Reset mid-run
    wr(IO | 30'd0, 32'h0000_00FF, 4'hF);
    chk("leds_ff", 32'(LEDS), 32'h0000_00FF);
    wr(IO | 30'd8, 32'd19, 4'hF);
    step(); step();
    chk("irq_before_reset", 32'(IRQ), 32'h1);
    wr(30'd7, 32'hCAFE_F00D, 4'hF);
    RESET = 1'b1; dADDR = IO | 30'd0; WD = 32'h0000_003C; BE = 4'hF; WE = 1'b1;
    step();
    RESET = 1'b0; WE = 1'b0;
    chk("leds_after_reset", 32'(LEDS), 32'h0);
    chk("irq_after_reset", 32'(IRQ), 32'h0);
    rd("timer_after_reset_0", IO | 30'd8, 32'h0, 32'hFFFF_FFFF);
    rd("timer_after_reset_1", IO | 30'd8, 32'h1, 32'hFFFF_FFFF);
    chk("irq_cmp0_after_reset", 32'(IRQ), 32'h1);
    rd("ram_preserved", 30'd7, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    rd("gpio0_after_reset", IO | 30'd0, 32'h0, 32'hFFFF_FFFF);

    step(); step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
